// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access-size
// codes, the default memory timeout and an alignment helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsuState_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int TIMEOUT_DEFAULT = 255;

  // An access is aligned when the low address bits are a multiple of its size.
  function automatic logic isAligned(input logic [2:0] offset, input logic [1:0] size);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (offset[0] == 1'b0);
      SZ_W:    ok = (offset[1:0] == 2'b00);
      default: ok = (offset == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the 64-bit data port: byte enables, store
// data shifted into the addressed lanes, and load extraction with extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [63:0] storeData,
  input  logic [63:0] memRdata,
  output logic [7:0]  byteEn,
  output logic [63:0] storeLanes,
  output logic [63:0] loadData
);

  logic [63:0] shifted;

  assign storeLanes = storeData << {offset, 3'b000};
  assign shifted    = memRdata >> {offset, 3'b000};

  always_comb begin
    byteEn = 8'hFF;
    case (size)
      SZ_B:    byteEn = 8'h01 << offset;
      SZ_H:    byteEn = 8'h03 << offset;
      SZ_W:    byteEn = 8'h0F << offset;
      default: byteEn = 8'hFF;
    endcase
  end

  always_comb begin
    loadData = shifted;
    case (size)
      SZ_B:    loadData = {{56{signExt & shifted[7]}},  shifted[7:0]};
      SZ_H:    loadData = {{48{signExt & shifted[15]}}, shifted[15:0]};
      SZ_W:    loadData = {{32{signExt & shifted[31]}}, shifted[31:0]};
      default: loadData = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack data-memory handshake with core stall control.
// Optional request timeout enabled by defining LSU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access in flight; legal request stalls and launches, illegal pulses Fault
// REQ   | mem_req held with fields stable, waiting for mem_ack (or timeout)
// DONE  | access finished, Stall low, ReadData valid; always back to IDLE
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] Address,
  input  logic [DW-1:0] WriteData,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [1:0]    Size,
  input  logic          SignExt,
  output logic [DW-1:0] ReadData,
  output logic          Stall,
  output logic          Fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  if (TIMEOUT < 1) begin : gTimeoutCheck
    $error("load_store_unit: TIMEOUT must be at least 1");
  end

  lsuState_t state, stateNext;

  logic [1:0]    regSize;
  logic          regSignExt;
  logic [2:0]    regOffset;
  logic          accessReq;
  logic          rejected;
  logic          startReq;
  logic [2:0]    laneOffset;
  logic [1:0]    laneSize;
  logic [7:0]    byteEn;
  logic [DW-1:0] storeLanes;
  logic [DW-1:0] loadData;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] tmoCnt;
  logic          tmoHit;
  logic          timedOut;
  assign tmoHit = (tmoCnt == '0);
`endif

  assign accessReq = MemRead | MemWrite;
  assign rejected  = (MemRead & MemWrite) | ~isAligned(Address[2:0], Size);
  assign startReq  = (state == IDLE) & accessReq & ~rejected;

  // Live request fields steer the lanes at launch; the registered ones at completion.
  assign laneOffset = (state == IDLE) ? Address[2:0] : regOffset;
  assign laneSize   = (state == IDLE) ? Size : regSize;

  lsu_lane_align uLaneAlign (
    .offset     (laneOffset),
    .size       (laneSize),
    .signExt    (regSignExt),
    .storeData  (WriteData),
    .memRdata   (mem_rdata),
    .byteEn     (byteEn),
    .storeLanes (storeLanes),
    .loadData   (loadData)
  );

  always_comb begin
    stateNext = state;
    Stall     = 1'b0;
    Fault     = 1'b0;
    case (state)
      IDLE: begin
        if (accessReq) begin
          if (rejected) begin
            Fault = 1'b1;
          end else begin
            Stall     = 1'b1;
            stateNext = REQ;
          end
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (mem_ack) stateNext = DONE;
`ifdef LSU_TIMEOUT_EN
        else if (tmoHit) stateNext = DONE;
`endif
      end
      DONE: begin
`ifdef LSU_TIMEOUT_EN
        Fault = timedOut;
`endif
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ReadData   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      regSize    <= SZ_B;
      regSignExt <= 1'b0;
      regOffset  <= 3'b000;
`ifdef LSU_TIMEOUT_EN
      tmoCnt     <= '0;
      timedOut   <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (startReq) begin
            mem_req    <= 1'b1;
            mem_we     <= MemWrite;
            mem_addr   <= {Address[AW-1:3], 3'b000};
            mem_be     <= byteEn;
            mem_wdata  <= storeLanes;
            regSize    <= Size;
            regSignExt <= SignExt;
            regOffset  <= Address[2:0];
`ifdef LSU_TIMEOUT_EN
            tmoCnt     <= TW'(TIMEOUT - 1);
            timedOut   <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadData <= loadData;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmoHit) begin
            mem_req  <= 1'b0;
            timedOut <= 1'b1;
            if (!mem_we) ReadData <= '0;
          end else begin
            tmoCnt <= tmoCnt - 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; the timeout scenario is
// built only when LSU_TIMEOUT_EN is defined (DUT instantiated with TIMEOUT=4).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [63:0] Address;
  logic [63:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        SignExt;
  logic [63:0] ReadData;
  logic        Stall;
  logic        Fault;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int testsRun    = 0;
  int testsFailed = 0;

  // Values captured by runAccess
  int          stallCycles;
  logic        sawDone;
  logic        capReq;
  logic        capWe;
  logic [63:0] capAddr;
  logic [7:0]  capBe;
  logic [63:0] capWdata;
  logic [63:0] capRd;
  logic        capFault;

  always #5 Clk = ~Clk;

  load_store_unit #(.AW(64), .DW(64), .TIMEOUT(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Size      (Size),
    .SignExt   (SignExt),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Fault     (Fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Drives one access; memory acks k cycles after REQ entry (k<0: never).
  task automatic runAccess(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [1:0] sz, input logic sx,
                           input int k, input logic [63:0] rdat);
    logic done;
    @(posedge Clk); #1;
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd;
    Size = sz; SignExt = sx; mem_ack = 1'b0; mem_rdata = rdat;
    stallCycles = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c >= 1) mem_ack = (c - 1 == k);
      @(negedge Clk);
      if (c == 1) begin
        capReq = mem_req; capWe = mem_we; capAddr = mem_addr;
        capBe = mem_be; capWdata = mem_wdata;
      end
      if (Stall) stallCycles++;
      else begin
        done = 1'b1; capRd = ReadData; capFault = Fault;
      end
      @(posedge Clk); #1;
      mem_ack = 1'b0;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    sawDone = done;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    testsRun++; if (ReadData !== 64'h0) begin testsFailed++; $display("FAIL reset_rdata got=%h exp=0", ReadData); end
    testsRun++; if (Stall !== 1'b0) begin testsFailed++; $display("FAIL reset_stall got=%b exp=0", Stall); end
    testsRun++; if (Fault !== 1'b0) begin testsFailed++; $display("FAIL reset_fault got=%b exp=0", Fault); end
    testsRun++; if (mem_req !== 1'b0) begin testsFailed++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    testsRun++; if (mem_we !== 1'b0) begin testsFailed++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    testsRun++; if (mem_addr !== 64'h0) begin testsFailed++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    testsRun++; if (mem_be !== 8'h0) begin testsFailed++; $display("FAIL reset_be got=%h exp=0", mem_be); end
    testsRun++; if (mem_wdata !== 64'h0) begin testsFailed++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_load_dword();
    runAccess(1'b1, 1'b0, 64'h40, 64'h0, SZ_D, 1'b0, 1, 64'h1122334455667788);
    testsRun++; if (sawDone !== 1'b1) begin testsFailed++; $display("FAIL ld_d_done got=%b exp=1", sawDone); end
    testsRun++; if (capReq !== 1'b1) begin testsFailed++; $display("FAIL ld_d_req got=%b exp=1", capReq); end
    testsRun++; if (capWe !== 1'b0) begin testsFailed++; $display("FAIL ld_d_we got=%b exp=0", capWe); end
    testsRun++; if (capBe !== 8'hFF) begin testsFailed++; $display("FAIL ld_d_be got=%h exp=ff", capBe); end
    testsRun++; if (capAddr !== 64'h40) begin testsFailed++; $display("FAIL ld_d_addr got=%h exp=40", capAddr); end
    testsRun++; if (stallCycles != 3) begin testsFailed++; $display("FAIL ld_d_stall got=%0d exp=3", stallCycles); end
    testsRun++; if (capRd !== 64'h1122334455667788) begin testsFailed++; $display("FAIL ld_d_rdata got=%h exp=1122334455667788", capRd); end
    testsRun++; if (capFault !== 1'b0) begin testsFailed++; $display("FAIL ld_d_fault got=%b exp=0", capFault); end
  endtask

  task automatic test_load_byte();
    runAccess(1'b1, 1'b0, 64'h43, 64'h0, SZ_B, 1'b1, 1, 64'hA1B2C3D480E5F607);
    testsRun++; if (capAddr !== 64'h40) begin testsFailed++; $display("FAIL ld_b_addr got=%h exp=40", capAddr); end
    testsRun++; if (capBe !== 8'h08) begin testsFailed++; $display("FAIL ld_b_be got=%h exp=08", capBe); end
    testsRun++; if (capRd !== 64'hFFFFFFFFFFFFFF80) begin testsFailed++; $display("FAIL ld_b_sext got=%h exp=ffffffffffffff80", capRd); end
    runAccess(1'b1, 1'b0, 64'h43, 64'h0, SZ_B, 1'b0, 2, 64'hA1B2C3D480E5F607);
    testsRun++; if (capRd !== 64'h80) begin testsFailed++; $display("FAIL ld_b_zext got=%h exp=80", capRd); end
    testsRun++; if (stallCycles != 4) begin testsFailed++; $display("FAIL ld_b_stall_k2 got=%0d exp=4", stallCycles); end
  endtask

  task automatic test_load_word_half();
    runAccess(1'b1, 1'b0, 64'h44, 64'h0, SZ_W, 1'b1, 0, 64'h8765432100000000);
    testsRun++; if (stallCycles != 2) begin testsFailed++; $display("FAIL ld_w_stall_k0 got=%0d exp=2", stallCycles); end
    testsRun++; if (capBe !== 8'hF0) begin testsFailed++; $display("FAIL ld_w_be got=%h exp=f0", capBe); end
    testsRun++; if (capRd !== 64'hFFFFFFFF87654321) begin testsFailed++; $display("FAIL ld_w_sext got=%h exp=ffffffff87654321", capRd); end
    runAccess(1'b1, 1'b0, 64'h02, 64'h0, SZ_H, 1'b0, 1, 64'h00000000F00D0000);
    testsRun++; if (capBe !== 8'h0C) begin testsFailed++; $display("FAIL ld_h_be got=%h exp=0c", capBe); end
    testsRun++; if (capAddr !== 64'h0) begin testsFailed++; $display("FAIL ld_h_addr got=%h exp=0", capAddr); end
    testsRun++; if (capRd !== 64'hF00D) begin testsFailed++; $display("FAIL ld_h_zext got=%h exp=f00d", capRd); end
  endtask

  task automatic test_store();
    runAccess(1'b0, 1'b1, 64'h26, 64'hBEEF, SZ_H, 1'b0, 0, 64'hDEADDEADDEADDEAD);
    testsRun++; if (capWe !== 1'b1) begin testsFailed++; $display("FAIL st_h_we got=%b exp=1", capWe); end
    testsRun++; if (capBe !== 8'hC0) begin testsFailed++; $display("FAIL st_h_be got=%h exp=c0", capBe); end
    testsRun++; if (capWdata !== 64'hBEEF000000000000) begin testsFailed++; $display("FAIL st_h_wdata got=%h exp=beef000000000000", capWdata); end
    testsRun++; if (capAddr !== 64'h20) begin testsFailed++; $display("FAIL st_h_addr got=%h exp=20", capAddr); end
    testsRun++; if (capRd !== 64'hF00D) begin testsFailed++; $display("FAIL st_h_rdata_kept got=%h exp=f00d", capRd); end
    runAccess(1'b0, 1'b1, 64'h07, 64'h5A, SZ_B, 1'b0, 1, 64'h0);
    testsRun++; if (capBe !== 8'h80) begin testsFailed++; $display("FAIL st_b_be got=%h exp=80", capBe); end
    testsRun++; if (capWdata !== 64'h5A00000000000000) begin testsFailed++; $display("FAIL st_b_wdata got=%h exp=5a00000000000000", capWdata); end
    testsRun++; if (capRd !== 64'hF00D) begin testsFailed++; $display("FAIL st_b_rdata_kept got=%h exp=f00d", capRd); end
  endtask

  task automatic test_reject();
    logic [63:0] addrs [3] = '{64'h42, 64'h40, 64'h43};
    logic        rds   [3] = '{1'b1, 1'b1, 1'b0};
    logic        wrs   [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  szs   [3] = '{SZ_W, SZ_D, SZ_H};
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      Address = addrs[i]; MemRead = rds[i]; MemWrite = wrs[i]; Size = szs[i];
      @(negedge Clk);
      testsRun++; if (Fault !== 1'b1) begin testsFailed++; $display("FAIL rej%0d_fault got=%b exp=1", i, Fault); end
      testsRun++; if (Stall !== 1'b0) begin testsFailed++; $display("FAIL rej%0d_stall got=%b exp=0", i, Stall); end
      @(posedge Clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge Clk);
      testsRun++; if (mem_req !== 1'b0) begin testsFailed++; $display("FAIL rej%0d_req got=%b exp=0", i, mem_req); end
      testsRun++; if (Fault !== 1'b0) begin testsFailed++; $display("FAIL rej%0d_pulse got=%b exp=0", i, Fault); end
    end
    testsRun++; if (ReadData !== 64'hF00D) begin testsFailed++; $display("FAIL rej_rdata_kept got=%h exp=f00d", ReadData); end
  endtask

  task automatic test_reset_mid();
    @(posedge Clk); #1;
    MemRead = 1'b1; Address = 64'h40; Size = SZ_D; SignExt = 1'b0;
    mem_ack = 1'b0; mem_rdata = 64'hCAFEF00DCAFEF00D;
    @(posedge Clk); #1;
    testsRun++; if (mem_req !== 1'b1) begin testsFailed++; $display("FAIL rstmid_req_before got=%b exp=1", mem_req); end
    Reset = 1'b1; MemRead = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    testsRun++; if (mem_req !== 1'b0) begin testsFailed++; $display("FAIL rstmid_req got=%b exp=0", mem_req); end
    testsRun++; if (Stall !== 1'b0) begin testsFailed++; $display("FAIL rstmid_stall got=%b exp=0", Stall); end
    testsRun++; if (mem_be !== 8'h0) begin testsFailed++; $display("FAIL rstmid_be got=%h exp=0", mem_be); end
    @(posedge Clk); #1;
    mem_ack = 1'b1;
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      testsRun++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin testsFailed++; $display("FAIL rstmid_late_ack%0d got req=%b stall=%b exp=0/0", c, mem_req, Stall); end
      testsRun++; if (ReadData !== 64'h0) begin testsFailed++; $display("FAIL rstmid_rdata%0d got=%h exp=0", c, ReadData); end
    end
  endtask

  task automatic test_back_to_back();
    runAccess(1'b1, 1'b0, 64'h18, 64'h0, SZ_D, 1'b0, 0, 64'h0123456789ABCDEF);
    testsRun++; if (capRd !== 64'h0123456789ABCDEF) begin testsFailed++; $display("FAIL b2b_first got=%h exp=0123456789abcdef", capRd); end
    runAccess(1'b1, 1'b0, 64'h1E, 64'h0, SZ_H, 1'b1, 0, 64'h9ABC000000000000);
    testsRun++; if (capRd !== 64'hFFFFFFFFFFFF9ABC) begin testsFailed++; $display("FAIL b2b_second got=%h exp=ffffffffffff9abc", capRd); end
    testsRun++; if (capAddr !== 64'h18) begin testsFailed++; $display("FAIL b2b_addr got=%h exp=18", capAddr); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    runAccess(1'b1, 1'b0, 64'h40, 64'h0, SZ_D, 1'b0, -1, 64'h5555555555555555);
    testsRun++; if (sawDone !== 1'b1) begin testsFailed++; $display("FAIL tmo_done got=%b exp=1", sawDone); end
    testsRun++; if (stallCycles != 5) begin testsFailed++; $display("FAIL tmo_stall got=%0d exp=5", stallCycles); end
    testsRun++; if (capFault !== 1'b1) begin testsFailed++; $display("FAIL tmo_fault got=%b exp=1", capFault); end
    testsRun++; if (capRd !== 64'h0) begin testsFailed++; $display("FAIL tmo_rdata got=%h exp=0", capRd); end
    @(negedge Clk);
    testsRun++; if (Fault !== 1'b0 || mem_req !== 1'b0) begin testsFailed++; $display("FAIL tmo_after got fault=%b req=%b exp=0/0", Fault, mem_req); end
  endtask
`endif

  initial begin
    Reset = 1'b1; Address = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    Size = SZ_B; SignExt = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_load_dword();
    test_load_byte();
    test_load_word_half();
    test_store();
    test_reject();
    test_reset_mid();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
